// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer
// Sequences one USB low/full-speed packet transmission ahead of an NRZI
// encoder: presets the encoder, emits the SYNC field, passes packet bits
// through with zero latency while inserting bit-stuff zeros, then drives
// the EOP (SE0 cycles followed by one J cycle).
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst_n        in   synchronous reset, active-high (1 = reset)
//   start        in   request one packet transmission (honoured in IDLE only)
//   pkt_bit      in   raw packet bit, LSB-first from the source
//   pkt_valid    in   pkt_bit / pkt_last are valid
//   pkt_last     in   marks the final packet bit
//   pkt_ready    out  sequencer accepts pkt_bit this cycle
//   nrzi_init    out  one-cycle pulse presetting the NRZI register to J
//   tx_bit       out  unencoded bit to the NRZI encoder
//   tx_bit_valid out  NRZI encoder advances this cycle
//   se0          out  drive SE0 on dp/dm
//   j_drive      out  drive J for the final EOP cycle
//   tx_active    out  high from INIT through EOP_J
//   done         out  one-cycle pulse at packet completion
//
// State table
//   state   | meaning
//   IDLE    | waiting for start, all outputs low
//   INIT    | preset downstream NRZI register
//   SYNC    | emit the 8 SYNC_PAT bits, bit 0 first
//   DATA    | pass accepted packet bits straight through
//   STUFF   | emit a stuffed 0 after STUFF_LEN consecutive 1s
//   EOP_SE0 | drive SE0 for SE0_CYC cycles
//   EOP_J   | drive J for one cycle, pulse done

module usb_tx_sequencer #(
   parameter logic [7:0] SYNC_PAT  = 8'b1000_0000,
   parameter int         STUFF_LEN = 6,
   parameter int         SE0_CYC   = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic pkt_bit,
   input  logic pkt_valid,
   input  logic pkt_last,
   output logic pkt_ready,
   output logic nrzi_init,
   output logic tx_bit,
   output logic tx_bit_valid,
   output logic se0,
   output logic j_drive,
   output logic tx_active,
   output logic done
);

   localparam int ONES_W = $clog2(STUFF_LEN + 1);
   localparam int SE0_W  = (SE0_CYC > 1) ? $clog2(SE0_CYC) : 1;

   localparam logic [ONES_W-1:0] ONES_MAX  = ONES_W'(STUFF_LEN);
   localparam logic [ONES_W-1:0] ONES_PRE  = ONES_W'(STUFF_LEN - 1);
   localparam logic [SE0_W-1:0]  SE0_LOAD  = SE0_W'(SE0_CYC - 1);
   localparam logic [2:0]        SYNC_LAST = 3'd7;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      SYNC    = 3'd2,
      DATA    = 3'd3,
      STUFF   = 3'd4,
      EOP_SE0 = 3'd5,
      EOP_J   = 3'd6
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        sync_idx;
   logic [ONES_W-1:0] ones_cnt;
   logic [SE0_W-1:0]  se0_cnt;
   logic              last_q;
   logic              xfer;
   logic              stuff_due;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state    <= IDLE;
         sync_idx <= 3'd0;
         ones_cnt <= '0;
         se0_cnt  <= SE0_LOAD;
         last_q   <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == SYNC) begin
            sync_idx <= sync_idx + 3'd1;
         end else begin
            sync_idx <= 3'd0;
         end

         // Run length of emitted 1s; the SYNC bits count too, so the
         // final SYNC 1 contributes to the first stuff decision.
         if ((state == IDLE) || (state == INIT)) begin
            ones_cnt <= '0;
         end else if (tx_bit_valid) begin
            if (!tx_bit) begin
               ones_cnt <= '0;
            end else if (ones_cnt < ONES_MAX) begin
               ones_cnt <= ones_cnt + 1'b1;
            end
         end

         // SE0 down-counter: preloaded outside EOP_SE0, terminal count 0.
         if (state != EOP_SE0) begin
            se0_cnt <= SE0_LOAD;
         end else if (se0_cnt != '0) begin
            se0_cnt <= se0_cnt - 1'b1;
         end

         // Remembers that the last packet bit went out, so a trailing
         // stuff bit knows to continue into EOP.
         if (state == IDLE) begin
            last_q <= 1'b0;
         end else if (xfer && pkt_last) begin
            last_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      pkt_ready    = 1'b0;
      nrzi_init    = 1'b0;
      tx_bit       = 1'b0;
      tx_bit_valid = 1'b0;
      se0          = 1'b0;
      j_drive      = 1'b0;
      done         = 1'b0;
      xfer         = 1'b0;
      stuff_due    = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = INIT;
            end
         end

         INIT: begin
            nrzi_init = 1'b1;
            state_nxt = SYNC;
         end

         SYNC: begin
            tx_bit_valid = 1'b1;
            tx_bit       = SYNC_PAT[sync_idx];
            if (sync_idx == SYNC_LAST) begin
               state_nxt = DATA;
            end
         end

         DATA: begin
            pkt_ready = 1'b1;
            if (pkt_valid) begin
               xfer         = 1'b1;
               tx_bit       = pkt_bit;
               tx_bit_valid = 1'b1;
               stuff_due    = pkt_bit && (ones_cnt == ONES_PRE);
               if (stuff_due) begin
                  state_nxt = STUFF;
               end else if (pkt_last) begin
                  state_nxt = EOP_SE0;
               end
            end
         end

         STUFF: begin
            tx_bit       = 1'b0;
            tx_bit_valid = 1'b1;
            state_nxt    = last_q ? EOP_SE0 : DATA;
         end

         EOP_SE0: begin
            se0 = 1'b1;
            if (se0_cnt == '0) begin
               state_nxt = EOP_J;
            end
         end

         EOP_J: begin
            j_drive   = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign tx_active = (state != IDLE);

endmodule

// File: doc/usb_tx_sequencer.md
USB_TX_SEQUENCER -- requirements
Module: usb_tx_sequencer

Interface
REQ-001 Parameter SYNC_PAT, default 8'b1000_0000, sync field; bit 0 is sent first, so the sequence is 0,0,0,0,0,0,0,1.
REQ-002 Parameter STUFF_LEN, default 6, number of consecutive 1s that forces a stuffed 0.
REQ-003 Parameter SE0_CYC, default 2, number of SE0 cycles in the EOP.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-high (1 = reset).
REQ-006 start  input  1  pulse requesting one packet transmission.
REQ-007 pkt_bit  input  1  raw packet bit, LSB-first order supplied by the source.
REQ-008 pkt_valid  input  1  pkt_bit/pkt_last are valid.
REQ-009 pkt_last  input  1  qualifies the final packet bit.
REQ-010 pkt_ready  output  1  sequencer accepts pkt_bit this cycle.
REQ-011 nrzi_init  output  1  one-cycle pulse that presets the downstream NRZI register to 1 (idle J).
REQ-012 tx_bit  output  1  unencoded bit to the NRZI encoder.
REQ-013 tx_bit_valid  output  1  the NRZI encoder advances this cycle.
REQ-014 se0  output  1  drive SE0 on dp/dm.
REQ-015 j_drive  output  1  drive J for the final EOP cycle.
REQ-016 tx_active  output  1  high from INIT through EOP_J inclusive.
REQ-017 done  output  1  one-cycle pulse at packet completion.

Function
REQ-018 The FSM SHALL have the states IDLE, INIT, SYNC, DATA, STUFF, EOP_SE0 and EOP_J.
REQ-019 IDLE: all outputs 0; start=1 -> INIT next cycle.
REQ-020 INIT: nrzi_init=1 for exactly one cycle -> SYNC.
REQ-021 SYNC: tx_bit_valid=1 for exactly 8 cycles, tx_bit=SYNC_PAT[i] on cycle i; the 8-cycle count is held in a 3-bit counter -> DATA.
REQ-022 DATA: pkt_ready=1; a transfer occurs when pkt_valid&pkt_ready; on transfer tx_bit=pkt_bit and tx_bit_valid=1 in the same cycle (zero latency).
REQ-023 DATA with pkt_valid=0: tx_bit_valid=0 (stall); the ones counter and the state SHALL hold.
REQ-024 The ones counter SHALL count consecutive emitted 1s, starting with the SYNC cycles.
  - Increment on every tx_bit_valid with tx_bit=1; clear on every tx_bit_valid with tx_bit=0.
  - Width SHALL be clog2(STUFF_LEN+1) bits; it never exceeds STUFF_LEN.
REQ-025 When an emitted 1 brings the counter to STUFF_LEN, the next cycle SHALL be STUFF.
  - STUFF: tx_bit=0, tx_bit_valid=1, pkt_ready=0, counter cleared.
  - Exit to DATA, or to EOP_SE0 if the stuffed bit follows the last packet bit.
REQ-026 Transfer with pkt_last=1 -> EOP_SE0, unless a stuff is due; then STUFF first, then EOP_SE0.
REQ-027 EOP_SE0: se0=1, tx_bit_valid=0, pkt_ready=0 for SE0_CYC cycles -> EOP_J.
REQ-028 EOP_J: j_drive=1 and done=1 for one cycle -> IDLE.
REQ-029 start outside IDLE SHALL be ignored; a start in the same cycle as done SHALL be ignored.
REQ-030 pkt_ready SHALL be 0 in every state except DATA.
REQ-031 se0 and j_drive SHALL never be high together; se0, j_drive and tx_bit_valid are mutually exclusive.

Reset
REQ-032 rst_n=1 at a clock edge SHALL force IDLE, clear all counters, and drive every output to 0 on the following cycle.
  - This applies from any state, including mid-SYNC, mid-DATA and mid-EOP.
REQ-033 No done pulse SHALL be produced by a reset-aborted packet.

Verification
REQ-034 start pulse, 8 packet bits 0x5A LSB-first, always valid, last on bit 8 -> required response:
  - nrzi_init one cycle after start;
  - tx_bit sequence 0000000101011010;
  - se0 for 2 cycles, then j_drive+done for 1 cycle;
  - 20 cycles from start to done.
REQ-035 Packet of 8 ones, always valid -> required response:
  - sync final 1 counts, so a stuffed 0 follows the 5th packet 1;
  - pkt_ready=0 in that cycle;
  - emitted data bits 1111101 11.
REQ-036 Packet of exactly 5 ones, last on the 5th -> required response:
  - counter reaches 6 on the last bit;
  - stuffed 0 emitted, then se0 for 2 cycles.
REQ-037 pkt_valid dropped for 3 cycles after 3 packet ones -> required response:
  - tx_bit_valid=0 for those 3 cycles;
  - the next 2 ones trigger the stuff (counter held at 4 through the stall).
REQ-038 rst_n=1 during the 4th SYNC cycle -> required response:
  - all outputs 0 next cycle; no done;
  - a new start then produces a full 8-bit sync.
REQ-039 start asserted during DATA and in the done cycle -> required response: no effect; FSM returns to IDLE and stays there.
